tx_pulser: RTL
==============

Name: tx_pulser

Overview:
Transmit-side shot sequencer for the ultrasonic channel. Per shot, it drives the transducer fire pulse, waits a programmable fire-to-capture delay, then raises the capture-start strobe toward the acquisition wrapper. It then tracks that wrapper's ADC-open handshake until the capture completes. Shots repeat at a programmable repetition period (continuous mode) or on a single-shot request. Runs entirely in the i_ad_clk domain, alongside the acquisition path.

Parameters:
PERIOD_W, 24, width of repetition-period counter (cycles)
PULSE_W, 8, width of fire-pulse-width field
DELAY_W, 16, width of fire-to-start delay field
ACK_TIMEOUT, 1024, cycles to wait for i_ad_open rise before aborting a shot

Ports:
i_ad_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_enable  in  1  continuous-mode enable (level)
i_single  in  1  single-shot request; rising edge detected internally
i_clr_err  in  1  clears sticky o_overrun / o_timeout (1-cycle pulse)
i_period  in  PERIOD_W  shot-to-shot period in cycles, measured fire-rise to fire-rise
i_pulse_width  in  PULSE_W  fire high time in cycles (0 treated as 1)
i_delay  in  DELAY_W  cycles from fire fall to o_stout rise
i_ad_open  in  1  acquisition ack: rises when capture armed, falls when capture done
o_fire  out  1  transducer drive pulse
o_stout  out  1  capture-start strobe to acquisition wrapper
o_busy  out  1  high from shot accept until return to IDLE/HOLDOFF
o_shot_count  out  16  completed-shot counter, wraps 0xFFFF->0
o_overrun  out  1  sticky: period elapsed while previous capture still open
o_timeout  out  1  sticky: ack timeout occurred

Behaviour:
- All inputs are synchronous to i_ad_clk. Reset clears all outputs, counters and flags to 0, and the FSM goes to IDLE. Reset mid-shot drops o_fire/o_stout immediately.
- FSM states: IDLE, FIRE, DELAY, START, WAIT_DONE, HOLDOFF.
- IDLE: a shot is accepted on (i_enable=1) or (i_single rising edge with i_enable=0). i_single is ignored while i_enable=1 or while not in IDLE.
- Shot accept -> FIRE in the next cycle. o_fire=1 for exactly max(i_pulse_width,1) cycles. The period counter resets to 1 on the first FIRE cycle.
- DELAY: counts i_delay cycles after o_fire falls. With i_delay=0, DELAY is skipped.
- START: o_stout=1. It stays high until i_ad_open is sampled 1; o_stout drops the cycle after. Minimum high time is 2 cycles, so the receiver edge synchroniser sees it.
- Ack timeout: if i_ad_open has not risen within ACK_TIMEOUT cycles of o_stout rising, the block drops o_stout, sets o_timeout and goes to HOLDOFF. The shot is not counted.
- WAIT_DONE: waits for i_ad_open to fall. o_shot_count increments by 1 on the fall cycle, then the FSM goes to HOLDOFF.
- HOLDOFF (continuous): next FIRE when period count >= i_period. If the period already elapsed during WAIT_DONE, o_overrun is set and the next shot fires the cycle after HOLDOFF entry. Shots are never skipped, only deferred.
- HOLDOFF with i_enable=0 (or after a single shot): go to IDLE.
- i_enable falling mid-shot: the current shot completes normally; no abort.
- Period counter saturates at all-ones. i_period=0 or any value below the shot length means back-to-back shots.
- Config inputs are sampled only at shot accept. Mid-shot changes take effect on the next shot.
- i_clr_err clears both sticky flags. If a clear and a set event occur in the same cycle, the set wins.
- o_busy=1 in FIRE, DELAY, START, WAIT_DONE.

Optional Feature:
TX_BURST_EN: when defined, adds input i_burst_n[3:0]. FIRE emits max(i_burst_n,1) pulses, each of width max(i_pulse_width,1), separated by low gaps of the same width. DELAY starts after the last pulse falls. When undefined, the port is absent and exactly one pulse is emitted.

Test Plan:
- Single shot, pw=3, delay=5: i_single edge -> o_fire high cycles 1-3; o_stout rises cycle 9; model ack at +4, ack fall at +100 -> o_shot_count=1, FSM returns to IDLE.
- Continuous, period=200, capture 50 cycles: fire rising edges exactly 200 cycles apart across 10 shots; o_overrun stays 0; count=10.
- Overrun: period=40, capture 100 cycles -> o_overrun=1; next fire 1 cycle after HOLDOFF entry; i_clr_err -> flag 0.
- Ack timeout: i_ad_open held 0 -> o_stout drops after 1024 cycles, o_timeout=1, count unchanged; next shot proceeds normally.
- Reset mid-DELAY, and i_enable drop mid-WAIT_DONE: reset drops all outputs asynchronously; disable completes the shot (count+1), then IDLE with no further fire.
- pw=0, delay=0, count wrap preset near 0xFFFF: o_fire high 1 cycle; o_stout one cycle after fire falls; count wraps 0xFFFF->0x0000.

Source files
------------

// File: rtl/tx_pulser.sv
// tx_pulser: per-shot fire pulse, fire-to-capture delay, capture-start strobe and ADC-open ack tracking.
// Define TX_BURST_EN to add i_burst_n and fire a burst of equal-width pulses per shot.
module tx_pulser #(
  parameter int PERIOD_W    = 24,
  parameter int PULSE_W     = 8,
  parameter int DELAY_W     = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                i_ad_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_single,
  input  logic                i_clr_err,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [PULSE_W-1:0]  i_pulse_width,
  input  logic [DELAY_W-1:0]  i_delay,
`ifdef TX_BURST_EN
  input  logic [3:0]          i_burst_n,
`endif
  input  logic                i_ad_open,
  output logic                o_fire,
  output logic                o_stout,
  output logic                o_busy,
  output logic [15:0]         o_shot_count,
  output logic                o_overrun,
  output logic                o_timeout
);
  localparam int AW  = $clog2(ACK_TIMEOUT + 1);
  localparam int TW0 = (PULSE_W > DELAY_W) ? PULSE_W : DELAY_W;
  localparam int TW  = (TW0 > AW) ? TW0 : AW;
  typedef enum logic [2:0] {IDLE, FIRE, DELAY, START, WAIT_DONE, HOLDOFF} state_t;
  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, per_q, per_d;
  logic [PULSE_W-1:0]  pw_q, pw_d, pw_eff;
  logic [DELAY_W-1:0]  dly_q, dly_d;
  logic [15:0]         shot_q, shot_d;
  logic                cont_q, cont_d, ack_q, ack_d, ovr_q, ovr_d, tmo_q, tmo_d;
  logic                fire_q, fire_d, stout_q, stout_d, single_q;
  logic                accept, pulse_done, ovr_set, tmo_set;
`ifdef TX_BURST_EN
  logic [3:0]          burst_q, burst_d, idx_q, idx_d, burst_eff;
  logic                gap_q, gap_d, last_pulse;
`endif
  always_comb begin
    pw_eff     = (pw_q == '0) ? PULSE_W'(1) : pw_q;
    pulse_done = tmr_q >= TW'(pw_eff);
    accept     = (state_q == IDLE && (i_enable || (i_single && !single_q))) ||
                 (state_q == HOLDOFF && cont_q && i_enable && per_cnt_q >= per_q);
    state_d    = state_q;
    tmr_d      = tmr_q + 1'b1;
    per_cnt_d  = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;
    per_d      = per_q;
    pw_d       = pw_q;
    dly_d      = dly_q;
    cont_d     = cont_q;
    ack_d      = 1'b0;
    shot_d     = shot_q;
    ovr_set    = 1'b0;
    tmo_set    = 1'b0;
`ifdef TX_BURST_EN
    burst_eff  = (burst_q == '0) ? 4'd1 : burst_q;
    last_pulse = (idx_q + 4'd1) >= burst_eff;
    burst_d    = burst_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
`endif
    if (accept) begin
      state_d   = FIRE;
      tmr_d     = TW'(1);
      per_cnt_d = PERIOD_W'(1);
      per_d     = i_period;
      pw_d      = i_pulse_width;
      dly_d     = i_delay;
      cont_d    = i_enable;
`ifdef TX_BURST_EN
      burst_d   = i_burst_n;
      idx_d     = '0;
      gap_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        FIRE: if (pulse_done) begin
          tmr_d = TW'(1);
`ifdef TX_BURST_EN
          if (gap_q) begin
            gap_d = 1'b0;
            idx_d = idx_q + 4'd1;
          end else if (!last_pulse) gap_d = 1'b1;
          else state_d = (dly_q == '0) ? START : DELAY;
`else
          state_d = (dly_q == '0) ? START : DELAY;
`endif
        end
        DELAY: if (tmr_q >= TW'(dly_q)) begin
          state_d = START;
          tmr_d   = TW'(1);
        end
        START: begin
          // an ack seen in the first strobe cycle is held so the strobe still lasts two cycles
          ack_d = ack_q | i_ad_open;
          if (ack_d && tmr_q >= TW'(2)) state_d = WAIT_DONE;
          else if (tmr_q >= TW'(ACK_TIMEOUT)) begin
            state_d = HOLDOFF;
            tmo_set = 1'b1;
          end
        end
        WAIT_DONE: begin
          ovr_set = cont_q && i_ad_open && per_cnt_q >= per_q;
          if (!i_ad_open) begin
            state_d = HOLDOFF;
            shot_d  = shot_q + 1'b1;
          end
        end
        HOLDOFF: if (!(cont_q && i_enable)) state_d = IDLE;
        default: ;
      endcase
    end
    ovr_d   = ovr_set | (ovr_q & ~i_clr_err);
    tmo_d   = tmo_set | (tmo_q & ~i_clr_err);
`ifdef TX_BURST_EN
    fire_d  = (state_d == FIRE) && !gap_d;
`else
    fire_d  = state_d == FIRE;
`endif
    stout_d = state_d == START;
  end
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      per_cnt_q <= '0;
      per_q     <= '0;
      pw_q      <= '0;
      dly_q     <= '0;
      shot_q    <= '0;
      cont_q    <= 1'b0;
      ack_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      fire_q    <= 1'b0;
      stout_q   <= 1'b0;
      single_q  <= 1'b0;
`ifdef TX_BURST_EN
      burst_q   <= '0;
      idx_q     <= '0;
      gap_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      per_cnt_q <= per_cnt_d;
      per_q     <= per_d;
      pw_q      <= pw_d;
      dly_q     <= dly_d;
      shot_q    <= shot_d;
      cont_q    <= cont_d;
      ack_q     <= ack_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
      fire_q    <= fire_d;
      stout_q   <= stout_d;
      single_q  <= i_single;
`ifdef TX_BURST_EN
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
`endif
    end
  end
  assign o_fire       = fire_q;
  assign o_stout      = stout_q;
  assign o_busy       = (state_q != IDLE) && (state_q != HOLDOFF);
  assign o_shot_count = shot_q;
  assign o_overrun    = ovr_q;
  assign o_timeout    = tmo_q;
endmodule
